// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer family: FSM state encoding,
// default word width and the even-parity helper.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Even parity over a zero-extended word; zero padding does not change the XOR.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out serializer with a valid/ready word intake.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic             sdo_r, sdo_s;
  logic             valid_r, valid_s;
  logic             done_r, done_s;
  logic             ready_r, ready_s;
  logic             accept_s;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_r, par_s;
`endif

  // Next state, and the output values that state will present one cycle later.
  always_comb begin
    accept_s = s_valid & ready_r;
    state_s  = state_r;
    cnt_s    = cnt_r;
    shreg_s  = shreg_r;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_s    = par_r;
`endif
    if (accept_s) begin
      state_s = SHIFT;
      cnt_s   = {CNT_W{1'b0}};
      shreg_s = s_data;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_s   = even_parity(32'(s_data));
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        SHIFT: begin
          if (cnt_r == LAST_CNT) begin
`ifdef PISO_SERIALIZER_PARITY_EN
            state_s = PARITY;
`else
            state_s = IDLE;
`endif
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end

    case (state_s)
      SHIFT:   sdo_s = shreg_s[WIDTH-1];
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY:  sdo_s = par_s;
`endif
      default: sdo_s = 1'b0;
    endcase

    valid_s = (state_s != IDLE);
`ifdef PISO_SERIALIZER_PARITY_EN
    done_s  = (state_s == PARITY);
`else
    done_s  = (state_s == SHIFT) && (cnt_s == LAST_CNT);
`endif
    ready_s = (state_s == IDLE) || done_s;
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      shreg_r <= {WIDTH{1'b0}};
      sdo_r   <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shreg_r <= shreg_s;
      sdo_r   <= sdo_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      ready_r <= ready_s;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign s_ready   = ready_r;
  assign sdo       = sdo_r;
  assign sdo_valid = valid_r;
  assign busy      = valid_r;
  assign done      = done_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer at WIDTH=4 and WIDTH=8; follows
// PISO_SERIALIZER_PARITY_EN to pick the expected frame shape.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       v4, r4, sdo4, sv4, b4, dn4;
  logic [3:0] d4;
  logic       v8, r8, sdo8, sv8, b8, dn8;
  logic [7:0] d8;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sipo;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL4 = 5;
  localparam int FL8 = 9;
`else
  localparam int FL4 = 4;
  localparam int FL8 = 8;
`endif

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .s_valid(v4), .s_ready(r4), .s_data(d4),
    .sdo(sdo4), .sdo_valid(sv4), .busy(b4), .done(dn4)
  );

  piso_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .s_valid(v8), .s_ready(r8), .s_data(d8),
    .sdo(sdo8), .sdo_valid(sv8), .busy(b8), .done(dn8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One cycle of the 4-bit instance, sampled on the falling edge.
  task automatic expect_cycle(input string tag, input logic e_sdo, input logic e_valid,
                              input logic e_done, input logic e_ready);
    @(negedge clk);
    check({tag, ".sdo"},   32'(sdo4), 32'(e_sdo));
    check({tag, ".valid"}, 32'(sv4),  32'(e_valid));
    check({tag, ".busy"},  32'(b4),   32'(e_valid));
    check({tag, ".done"},  32'(dn4),  32'(e_done));
    check({tag, ".ready"}, 32'(r4),   32'(e_ready));
    if (sv4) sipo = {sipo[2:0], sdo4};
  endtask

  // Caller presents v4=1/d4=data while idle. s_valid stays high and s_data is
  // scrambled mid-frame; nxt/nxt_v are presented in the last bit cycle.
  task automatic frame(input string tag, input logic [3:0] data,
                       input logic [3:0] nxt, input logic nxt_v);
    logic b;
    for (int k = 0; k < FL4; k++) begin
      b = (k < 4) ? data[3-k] : ^data;
      expect_cycle($sformatf("%s[%0d]", tag, k), b, 1'b1, k == FL4-1, k == FL4-1);
      if (k == FL4-1) begin
        d4 = nxt;
        v4 = nxt_v;
      end else begin
        d4 = ~data;
        v4 = 1'b1;
      end
    end
`ifndef PISO_SERIALIZER_PARITY_EN
    check({tag, ".sipo"}, 32'(sipo), 32'(data));
`endif
  endtask

  initial begin
    logic [7:0] w8;
    reset_n = 1'b0;
    v4 = 1'b0; d4 = 4'h0;
    v8 = 1'b0; d8 = 8'h00;
    sipo = 4'h0;
    repeat (2) @(negedge clk);
    expect_cycle("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst8.valid", 32'(sv8), 32'd0);
    reset_n = 1'b1;
    expect_cycle("rel", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single word 1011
    v4 = 1'b1; d4 = 4'b1011;
    frame("w1011", 4'b1011, 4'h0, 1'b0);
    expect_cycle("idle1", 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back A then 5: one continuous stream
    v4 = 1'b1; d4 = 4'hA;
    frame("wA", 4'hA, 4'h5, 1'b1);
    frame("w5", 4'h5, 4'h0, 1'b0);
    expect_cycle("idle2", 1'b0, 1'b0, 1'b0, 1'b1);

    // s_valid held and data changed while busy
    v4 = 1'b1; d4 = 4'hC;
    frame("wC", 4'hC, 4'h0, 1'b0);
    expect_cycle("idle3", 1'b0, 1'b0, 1'b0, 1'b1);

    // Word with odd weight: parity bit 1 when enabled
    v4 = 1'b1; d4 = 4'b0111;
    frame("w0111", 4'b0111, 4'h0, 1'b0);
    expect_cycle("idle4", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the second bit cycle of F
    v4 = 1'b1; d4 = 4'hF;
    expect_cycle("abort[0]", 1'b1, 1'b1, 1'b0, 1'b0);
    v4 = 1'b0;
    expect_cycle("abort[1]", 1'b1, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    expect_cycle("abort.rst", 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    expect_cycle("abort.after0", 1'b0, 1'b0, 1'b0, 1'b1);
    expect_cycle("abort.after1", 1'b0, 1'b0, 1'b0, 1'b1);

    // WIDTH=8 word 81
    w8 = 8'h81;
    v8 = 1'b1; d8 = w8;
    for (int k = 0; k < FL8; k++) begin
      @(negedge clk);
      check($sformatf("w81[%0d].sdo", k),   32'(sdo8), 32'((k < 8) ? w8[7-k] : ^w8));
      check($sformatf("w81[%0d].valid", k), 32'(sv8),  32'd1);
      check($sformatf("w81[%0d].done", k),  32'(dn8),  32'(k == FL8-1));
      if (k == 0) v8 = 1'b0;
    end
    @(negedge clk);
    check("w81.idle", 32'(sv8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
